// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared ALU opcodes and divider state encoding for the EX stage and ID decoder
package ex_stage_pkg;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_ADDI  = 5'd2;
    localparam logic [4:0] OP_SUB   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_ANDI  = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_ORI   = 5'd7;
    localparam logic [4:0] OP_XOR   = 5'd8;
    localparam logic [4:0] OP_XORI  = 5'd9;
    localparam logic [4:0] OP_NOR   = 5'd10;
    localparam logic [4:0] OP_SLT   = 5'd11;
    localparam logic [4:0] OP_SLTI  = 5'd12;
    localparam logic [4:0] OP_SLTU  = 5'd13;
    localparam logic [4:0] OP_SLTIU = 5'd14;
    localparam logic [4:0] OP_SLL   = 5'd15;
    localparam logic [4:0] OP_SRL   = 5'd16;
    localparam logic [4:0] OP_SRA   = 5'd17;
    localparam logic [4:0] OP_SLLV  = 5'd18;
    localparam logic [4:0] OP_SRLV  = 5'd19;
    localparam logic [4:0] OP_SRAV  = 5'd20;
    localparam logic [4:0] OP_LUI   = 5'd21;
    localparam logic [4:0] OP_JAL   = 5'd22;
    localparam logic [4:0] OP_MULT  = 5'd23;
    localparam logic [4:0] OP_MULTU = 5'd24;
    localparam logic [4:0] OP_DIV   = 5'd25;
    localparam logic [4:0] OP_DIVU  = 5'd26;
    localparam logic [4:0] OP_MFHI  = 5'd27;
    localparam logic [4:0] OP_MFLO  = 5'd28;
    localparam logic [4:0] OP_MTHI  = 5'd29;
    localparam logic [4:0] OP_MTLO  = 5'd30;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

    // Ops that touch HI/LO or the divider and therefore must wait out a running divide.
    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO) || (op == OP_MTHI) || (op == OP_MTLO) ||
               (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - 32-cycle restoring divider with operand latch, sign fix-up and done pulse
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state, state_next;
    logic [5:0]  count;
    logic [31:0] quo, rem, dvs, dvd_orig;
    logic        q_neg, r_neg, div_zero;
    logic [32:0] partial, diff;
    logic [31:0] quo_step, rem_step;

    function automatic logic [31:0] magnitude(input logic sgn, input logic [31:0] x);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_RUN;
            DIV_RUN:  if (count == 6'd0) state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        partial  = {rem, quo[31]};
        diff     = partial - {1'b0, dvs};
        quo_step = {quo[30:0], ~diff[32]};
        rem_step = diff[32] ? partial[31:0] : diff[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 6'd0;
            quo      <= 32'd0;
            rem      <= 32'd0;
            dvs      <= 32'd0;
            dvd_orig <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == DIV_IDLE) begin
            if (start) begin
                count    <= 6'd31;
                quo      <= magnitude(is_signed, dividend);
                rem      <= 32'd0;
                dvs      <= magnitude(is_signed, divisor);
                dvd_orig <= dividend;
                q_neg    <= is_signed && (dividend[31] ^ divisor[31]);
                r_neg    <= is_signed && dividend[31];
                div_zero <= (divisor == 32'd0);
            end
        end else begin
            quo <= quo_step;
            rem <= rem_step;
            if (count != 6'd0) count <= count - 6'd1;
        end
    end

    // Results are taken from the final step so HI/LO land on the edge ending the last RUN cycle.
    always_comb begin
        busy      = (state == DIV_RUN);
        done      = busy && (count == 6'd0);
        quotient  = div_zero ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - quo_step) : quo_step);
        remainder = div_zero ? dvd_orig      : (r_neg ? (32'd0 - rem_step) : rem_step);
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, HI/LO, divide-hazard stall (divider built when EX_DIV_EN is defined)
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  EX_aluop,
    input  logic [31:0] EX_readdata1,
    input  logic [31:0] EX_readdata2,
    input  logic [31:0] EX_imm,
    input  logic [4:0]  EX_shamt,
    input  logic [31:0] EX_pc,
    input  logic        EX_regwrite,
    input  logic        EX_memwrite,
    input  logic        EX_memread,
    output logic [31:0] EX_aluresult,
    output logic        EX_out_regwrite,
    output logic        EX_out_memwrite,
    output logic        EX_out_memread,
    output logic        EX_stall,
    output logic        EX_divbusy
);

    logic [31:0] hi, lo;
    logic [31:0] a, b;
    logic [63:0] mult_s, mult_u;
    logic        div_done;
    logic [31:0] div_quo, div_rem;

    assign a = EX_readdata1;
    assign b = EX_readdata2;
    // Sign-extended operands make the low 64 bits of the product the signed result.
    assign mult_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign mult_u = {32'd0, a} * {32'd0, b};

`ifdef EX_DIV_EN
    logic div_start;
    logic div_signed;

    assign div_start  = ((EX_aluop == OP_DIV) || (EX_aluop == OP_DIVU)) && !EX_stall;
    assign div_signed = (EX_aluop == OP_DIV);
    assign EX_stall   = EX_divbusy && is_hilo_op(EX_aluop);

    ex_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (div_signed),
        .dividend  (a),
        .divisor   (b),
        .busy      (EX_divbusy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign EX_stall   = 1'b0;
    assign EX_divbusy = 1'b0;
    assign div_done   = 1'b0;
    assign div_quo    = 32'd0;
    assign div_rem    = 32'd0;
`endif

    always_comb begin
        EX_aluresult = 32'd0;
        case (EX_aluop)
            OP_ADD:   EX_aluresult = a + b;
            OP_ADDI:  EX_aluresult = a + EX_imm;
            OP_SUB:   EX_aluresult = a - b;
            OP_AND:   EX_aluresult = a & b;
            OP_ANDI:  EX_aluresult = a & EX_imm;
            OP_OR:    EX_aluresult = a | b;
            OP_ORI:   EX_aluresult = a | EX_imm;
            OP_XOR:   EX_aluresult = a ^ b;
            OP_XORI:  EX_aluresult = a ^ EX_imm;
            OP_NOR:   EX_aluresult = ~(a | b);
            OP_SLT:   EX_aluresult = {31'd0, $signed(a) < $signed(b)};
            OP_SLTI:  EX_aluresult = {31'd0, $signed(a) < $signed(EX_imm)};
            OP_SLTU:  EX_aluresult = {31'd0, a < b};
            OP_SLTIU: EX_aluresult = {31'd0, a < EX_imm};
            OP_SLL:   EX_aluresult = b << EX_shamt;
            OP_SRL:   EX_aluresult = b >> EX_shamt;
            OP_SRA:   EX_aluresult = $unsigned($signed(b) >>> EX_shamt);
            OP_SLLV:  EX_aluresult = b << a[4:0];
            OP_SRLV:  EX_aluresult = b >> a[4:0];
            OP_SRAV:  EX_aluresult = $unsigned($signed(b) >>> a[4:0]);
            OP_LUI:   EX_aluresult = {EX_imm[15:0], 16'h0000};
            OP_JAL:   EX_aluresult = EX_pc + 32'd8;
            OP_MFHI:  EX_aluresult = hi;
            OP_MFLO:  EX_aluresult = lo;
            default:  EX_aluresult = 32'd0;
        endcase
    end

    always_comb begin
        EX_out_regwrite = EX_regwrite && !EX_stall;
        EX_out_memwrite = EX_memwrite && !EX_stall;
        EX_out_memread  = EX_memread  && !EX_stall;
    end

    // A finishing divide never collides with an EX write: every HI/LO writer stalls during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (div_done) begin
            hi <= div_rem;
            lo <= div_quo;
        end else if (!EX_stall) begin
            case (EX_aluop)
                OP_MULT:  {hi, lo} <= mult_s;
                OP_MULTU: {hi, lo} <= mult_u;
                OP_MTHI:  hi <= a;
                OP_MTLO:  lo <= a;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage (divider sequences selected by EX_DIV_EN)
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  aluop;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  shamt;
    logic        regw, memw, memr;
    logic [31:0] result;
    logic        out_regw, out_memw, out_memr, stall, divbusy;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .EX_aluop        (aluop),
        .EX_readdata1    (rd1),
        .EX_readdata2    (rd2),
        .EX_imm          (imm),
        .EX_shamt        (shamt),
        .EX_pc           (pc),
        .EX_regwrite     (regw),
        .EX_memwrite     (memw),
        .EX_memread      (memr),
        .EX_aluresult    (result),
        .EX_out_regwrite (out_regw),
        .EX_out_memwrite (out_memw),
        .EX_out_memread  (out_memr),
        .EX_stall        (stall),
        .EX_divbusy      (divbusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] im,
                                               input logic [4:0] sh);
        logic signed [31:0] sy;
        sy = y;
        case (op)
            OP_ADD:   return x + y;
            OP_ADDI:  return x + im;
            OP_SUB:   return x - y;
            OP_AND:   return x & y;
            OP_ANDI:  return x & im;
            OP_OR:    return x | y;
            OP_ORI:   return x | im;
            OP_XOR:   return x ^ y;
            OP_XORI:  return x ^ im;
            OP_NOR:   return ~(x | y);
            OP_SLT:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTI:  return ($signed(x) < $signed(im)) ? 32'd1 : 32'd0;
            OP_SLTU:  return (x < y) ? 32'd1 : 32'd0;
            OP_SLTIU: return (x < im) ? 32'd1 : 32'd0;
            OP_SLL:   return y << sh;
            OP_SRL:   return y >> sh;
            OP_SRA:   return sy >>> sh;
            OP_SLLV:  return y << (x % 32);
            OP_SRLV:  return y >> (x % 32);
            OP_SRAV:  return sy >>> (x % 32);
            OP_LUI:   return im * 32'h10000;
            OP_JAL:   return pc + 32'd8;
            OP_MFHI:  return m_hi;
            OP_MFLO:  return m_lo;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_commit(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sp;
        longint unsigned up;
        sp = longint'($signed(x)) * longint'($signed(y));
        up = longint'(x) * longint'(y);
        case (op)
            OP_MULT:  begin m_hi = sp[63:32]; m_lo = sp[31:0]; end
            OP_MULTU: begin m_hi = up[63:32]; m_lo = up[31:0]; end
            OP_MTHI:  m_hi = x;
            OP_MTLO:  m_lo = x;
            default:  ;
        endcase
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] im, input logic [4:0] sh, input logic rw);
        @(negedge clk);
        aluop = op; rd1 = x; rd2 = y; imm = im; shamt = sh;
        regw = rw; memw = ~rw; memr = rw;
        #1;
    endtask

    // Unstalled single op: compare result and control pass-through, then advance the model.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] im, input logic [4:0] sh,
                          input logic [31:0] exp, input logic rw);
        drive(op, x, y, im, sh, rw);
        chk(name, result, exp);
        chk({name, "_ctl"}, {29'd0, out_regw, out_memw, out_memr}, {29'd0, rw, ~rw, rw});
        chk({name, "_stall"}, {31'd0, stall}, 32'd0);
        model_commit(op, x, y);
    endtask

`ifdef EX_DIV_EN
    task automatic ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = x;
        end else if (sgn) begin
            m_lo = $signed(x) / $signed(y);
            m_hi = $signed(x) % $signed(y);
        end else begin
            m_lo = x / y;
            m_hi = x % y;
        end
    endtask
`endif

    vec_t vecs[$];

    initial begin
        rst = 1'b1; pc = 32'h0000_0100;
        aluop = OP_NOP; rd1 = 0; rd2 = 0; imm = 0; shamt = 0; regw = 0; memw = 0; memr = 0;
        repeat (2) @(posedge clk);
        drive(OP_NOP, 32'h1234, 32'h5678, 0, 0, 1'b0);
        chk("rst_nop", result, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, divbusy}, 32'd0);
        drive(OP_MFHI, 0, 0, 0, 0, 1'b0);
        chk("rst_hi", result, 32'd0);
        drive(OP_MFLO, 0, 0, 0, 0, 1'b0);
        chk("rst_lo", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        vecs = '{
            '{OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h0,        5'd0, 32'h80000000},
            '{OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h0,        5'd0, 32'h1},
            '{OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        5'd0, 32'h0},
            '{OP_SRA,   32'h0,        32'h80000000, 32'h0,        5'd4, 32'hF8000000},
            '{OP_ADDI,  32'h5,        32'h0,        32'hFFFFFFFF, 5'd0, 32'h4},
            '{OP_SUB,   32'h0,        32'h1,        32'h0,        5'd0, 32'hFFFFFFFF},
            '{OP_NOR,   32'h0,        32'h0,        32'h0,        5'd0, 32'hFFFFFFFF},
            '{OP_LUI,   32'h0,        32'h0,        32'h0000ABCD, 5'd0, 32'hABCD0000},
            '{OP_JAL,   32'h0,        32'h0,        32'h0,        5'd0, 32'h00000108},
            '{OP_SLLV,  32'h4,        32'h1,        32'h0,        5'd0, 32'h10},
            '{OP_SRLV,  32'h24,       32'h80000000, 32'h0,        5'd0, 32'h08000000},
            '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'h0,        5'd0, 32'h0},
            '{OP_MFHI,  32'h0,        32'h0,        32'h0,        5'd0, 32'hFFFFFFFF},
            '{OP_MFLO,  32'h0,        32'h0,        32'h0,        5'd0, 32'hFFFFFFFA},
            '{OP_MULTU, 32'hFFFFFFFE, 32'h3,        32'h0,        5'd0, 32'h0},
            '{OP_MFHI,  32'h0,        32'h0,        32'h0,        5'd0, 32'h2},
            '{OP_MFLO,  32'h0,        32'h0,        32'h0,        5'd0, 32'hFFFFFFFA},
            '{OP_MTHI,  32'h12345678, 32'h0,        32'h0,        5'd0, 32'h0},
            '{OP_MFHI,  32'h0,        32'h0,        32'h0,        5'd0, 32'h12345678},
            '{OP_SLTI,  32'h80000000, 32'h0,        32'h0,        5'd0, 32'h1},
            '{OP_SLTIU, 32'h80000000, 32'h0,        32'h0,        5'd0, 32'h0},
            '{5'd31,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h0},
            '{OP_XORI,  32'hF0F0F0F0, 32'h0,        32'h0000FFFF, 5'd0, 32'hF0F00F0F}
        };
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm,
                   vecs[i].sh, vecs[i].exp, i[0]);

        for (int i = 0; i < 300; i++) begin
            logic [4:0]  op;
            logic [31:0] x, y, im;
            logic [4:0]  sh;
            op = 5'($urandom_range(0, 31));
            if (op == OP_DIV || op == OP_DIVU) op = OP_MFLO;
            x = $urandom; y = $urandom; im = $urandom; sh = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d_op%0d", i, op), op, x, y, im, sh,
                   ref_result(op, x, y, im, sh), 1'($urandom_range(0, 1)));
        end

`ifdef EX_DIV_EN
        // DIV -7/2 followed by a dependent MFLO that must wait out the divide.
        drive(OP_DIV, 32'hFFFFFFF9, 32'h2, 0, 0, 1'b0);
        chk("div_issue_stall", {31'd0, stall}, 32'd0);
        ref_div(1'b1, 32'hFFFFFFF9, 32'h2);
        for (int c = 1; c <= 32; c++) begin
            drive(OP_MFLO, 0, 0, 0, 0, 1'b1);
            chk($sformatf("div_stall_c%0d", c), {30'd0, stall, divbusy}, 32'd3);
            chk($sformatf("div_ctl_c%0d", c), {31'd0, out_regw}, 32'd0);
        end
        drive(OP_MFLO, 0, 0, 0, 0, 1'b1);
        chk("div_mflo_stall", {30'd0, stall, divbusy}, 32'd0);
        chk("div_mflo", result, 32'hFFFFFFFD);
        run_op("div_mfhi", OP_MFHI, 0, 0, 0, 0, 32'hFFFFFFFF, 1'b1);
        chk("div_model_lo", m_lo, 32'hFFFFFFFD);

        // DIVU by zero with independent ADDs proceeding underneath.
        drive(OP_DIVU, 32'hA, 32'h0, 0, 0, 1'b0);
        ref_div(1'b0, 32'hA, 32'h0);
        for (int c = 1; c <= 32; c++) begin
            drive(OP_ADD, 32'd3, 32'd4, 0, 0, 1'b1);
            chk($sformatf("divu_add_c%0d", c), {result[29:0], stall, divbusy},
                {30'd7, 1'b0, 1'b1});
        end
        run_op("divu_mflo", OP_MFLO, 0, 0, 0, 0, m_lo, 1'b1);
        run_op("divu_mfhi", OP_MFHI, 0, 0, 0, 0, 32'h0000000A, 1'b1);

        // Reset in the middle of a divide aborts it and clears HI/LO.
        drive(OP_DIV, 32'd100, 32'd7, 0, 0, 1'b0);
        for (int c = 1; c <= 10; c++) drive(OP_NOP, 0, 0, 0, 0, 1'b0);
        chk("abort_busy_before", {31'd0, divbusy}, 32'd1);
        @(negedge clk);
        aluop = OP_MFLO; rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, divbusy}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); rst = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        run_op("abort_mflo", OP_MFLO, 0, 0, 0, 0, 32'd0, 1'b1);
        run_op("abort_mfhi", OP_MFHI, 0, 0, 0, 0, 32'd0, 1'b1);
`else
        // Divider absent: DIV is a NOP and nothing ever stalls.
        run_op("nodiv_mthi", OP_MTHI, 32'hCAFE0001, 0, 0, 0, 32'd0, 1'b0);
        run_op("nodiv_mtlo", OP_MTLO, 32'hCAFE0002, 0, 0, 0, 32'd0, 1'b0);
        run_op("nodiv_div", OP_DIV, 32'd8, 32'd2, 0, 0, 32'd0, 1'b1);
        for (int c = 1; c <= 34; c++) begin
            drive(OP_MFLO, 0, 0, 0, 0, 1'b1);
            chk($sformatf("nodiv_c%0d", c), {result[29:0], stall, divbusy},
                {30'h0AFE0002 & 30'h3FFFFFFF, 1'b0, 1'b0});
        end
        run_op("nodiv_mfhi", OP_MFHI, 0, 0, 0, 0, 32'hCAFE0001, 1'b1);
        run_op("nodiv_mflo", OP_MFLO, 0, 0, 0, 0, 32'hCAFE0002, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
